// File: rtl/id_pkg.sv
// Shared decode-stage definitions: immediate formats, default sizes and the
// RISC-V immediate extractor used by the decode latch.
package id_pkg;

  localparam int DefWordSize = 32;
  localparam int DefRegCount = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_mode_e;

  // Formats 5-7 are reserved and decode to a zero immediate.
  function automatic logic [31:0] decode_imm(input logic [31:0] ins, input logic [2:0] mode);
    logic [31:0] imm;
    imm = '0;
    case (mode)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// General-purpose register file: two read ports, one write port, with the
// write data forwarded to a read port addressing the register being written.
module id_regfile import id_pkg::*; #(
  parameter int WordSize = DefWordSize,
  parameter int RegCount = DefRegCount,
  localparam int RegBits = $clog2(RegCount)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RegBits-1:0]  raddr1_i,
  input  logic [RegBits-1:0]  raddr2_i,
  output logic [WordSize-1:0] rdata1_o,
  output logic [WordSize-1:0] rdata2_o,
  input  logic                we_i,
  input  logic [RegBits-1:0]  waddr_i,
  input  logic [WordSize-1:0] wdata_i
);

  logic [WordSize-1:0] regs_q [RegCount];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegCount; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0) rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
    if (raddr2_i != '0) rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: one-entry decode latch, register scoreboard, operand read with
// writeback bypass, and branch target / next-PC computation.
//   state | meaning
//   EMPTY | no instruction held; ready for fetch
//   FULL  | instruction held; issues to EX once hazard-free and EX is ready
module id_stage import id_pkg::*; #(
  parameter int WordSize = DefWordSize,
  parameter int RegCount = DefRegCount,
  localparam int RegBits = $clog2(RegCount)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [WordSize-1:0] ins,
  input  logic [WordSize-1:0] pc_in,
  input  logic [2:0]          immode,
  input  logic                rd_we,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [RegBits-1:0]  rdn,
  output logic [WordSize-1:0] rs1d,
  output logic [WordSize-1:0] rs2d,
  output logic [WordSize-1:0] imm,
  output logic [WordSize-1:0] pc,
  output logic                rd_we_out,
  input  logic                wbe,
  input  logic                wb_kill,
  input  logic [RegBits-1:0]  rdn_in,
  input  logic [WordSize-1:0] rdd,
  input  logic                flush,
  input  logic                addr_mode,
  input  logic                branch_taken,
  output logic [WordSize-1:0] npc,
  output logic [WordSize-1:0] branch_addr
);

  typedef enum logic {EMPTY, FULL} latch_state_e;

  latch_state_e        state_q;
  logic [WordSize-1:0] ins_q, pc_q;
  logic [2:0]          immode_q;
  logic                rd_we_q;
  logic [RegCount-1:0] pending_q, pending_d;

  logic [RegBits-1:0]  rs1n, rs2n;
  logic [31:0]         imm32;
  logic [WordSize-1:0] base, target;
  logic                full, hazard, issue, load, rs1_haz, rs2_haz;

  assign full  = (state_q == FULL);
  assign rs1n  = ins_q[15 +: RegBits];
  assign rs2n  = ins_q[20 +: RegBits];
  assign rdn   = ins_q[7 +: RegBits];

  // A wb_kill frees the register only from the next cycle; only wbe carries data to bypass.
  assign rs1_haz = (rs1n != '0) && pending_q[rs1n] && !(wbe && rdn_in == rs1n);
  assign rs2_haz = (rs2n != '0) && pending_q[rs2n] && !(wbe && rdn_in == rs2n);
  assign hazard  = full && (rs1_haz || rs2_haz);

  assign ex_valid = full && !hazard && !flush;
  assign issue    = ex_valid && ex_ready;
  assign if_ready = !full || issue || flush;
  assign load     = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      ins_q    <= '0;
      pc_q     <= '0;
      immode_q <= '0;
      rd_we_q  <= 1'b0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else if (load) begin
      state_q  <= FULL;
      ins_q    <= ins;
      pc_q     <= pc_in;
      immode_q <= immode;
      rd_we_q  <= rd_we;
    end else if (issue) begin
      state_q <= EMPTY;
    end
  end

  // Clear first, then set, so an issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wbe || wb_kill) pending_d[rdn_in] = 1'b0;
    if (issue && rd_we_q && rdn != '0) pending_d[rdn] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  id_regfile #(.WordSize(WordSize), .RegCount(RegCount)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs1n),
    .raddr2_i (rs2n),
    .rdata1_o (rs1d),
    .rdata2_o (rs2d),
    .we_i     (wbe),
    .waddr_i  (rdn_in),
    .wdata_i  (rdd)
  );

  assign imm32     = decode_imm(ins_q[31:0], immode_q);
  assign imm       = WordSize'($signed(imm32));
  assign pc        = pc_q;
  assign rd_we_out = rd_we_q;

  assign base        = addr_mode ? rs1d : pc_q;
  assign target      = base + imm;
  assign branch_addr = {target[WordSize-1:1], 1'b0};
  assign npc         = branch_taken ? branch_addr : pc_q + WordSize'(4);

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios, then random traffic checked through
// an issue scoreboard against an architectural model of the stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, rd_we, ex_valid, ex_ready, rd_we_out;
  logic        wbe, wb_kill, flush, addr_mode, branch_taken;
  logic [31:0] ins, pc_in, rs1d, rs2d, imm, pc, rdd, npc, branch_addr;
  logic [2:0]  immode;
  logic [4:0]  rdn, rdn_in;

  always #5 clk = ~clk;

  id_stage #(.WordSize(32), .RegCount(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .ins(ins),
    .pc_in(pc_in), .immode(immode), .rd_we(rd_we), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .rdn(rdn), .rs1d(rs1d), .rs2d(rs2d), .imm(imm), .pc(pc),
    .rd_we_out(rd_we_out), .wbe(wbe), .wb_kill(wb_kill), .rdn_in(rdn_in), .rdd(rdd),
    .flush(flush), .addr_mode(addr_mode), .branch_taken(branch_taken), .npc(npc),
    .branch_addr(branch_addr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [2:0]  mode;
    logic        we;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        cur_h;
  logic [31:0] m_regs [32];
  logic        m_pend [32];
  logic        m_full;
  logic        exp_ev, exp_ir, mon_en = 1'b0;

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] s;
    s = 32'd1 << (n - 1);
    return (v ^ s) - s;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] m);
    case (m)
      3'd0: return sext(i >> 20, 12);
      3'd1: return sext(((i >> 25) << 5) | ((i >> 7) & 32'd31), 12);
      3'd2: return sext((((i >> 31) & 32'd1) << 12) | (((i >> 7) & 32'd1) << 11) |
                        (((i >> 25) & 32'd63) << 5) | (((i >> 8) & 32'd15) << 1), 13);
      3'd3: return i & 32'hFFFFF000;
      3'd4: return sext((((i >> 31) & 32'd1) << 20) | (((i >> 12) & 32'd255) << 12) |
                        (((i >> 20) & 32'd1) << 11) | (((i >> 21) & 32'd1023) << 1), 21);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] fld(input logic [31:0] i, input int sh);
    return 5'((i >> sh) & 32'd31);
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (wbe && rdn_in == s) return rdd;
    return m_regs[s];
  endfunction

  function automatic logic blocked(input logic [4:0] s);
    return (s != 5'd0) && m_pend[s] && !(wbe && rdn_in == s);
  endfunction

  // Monitor: every cycle compare handshakes; on each issue pop and compare the decoded instruction.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ex_valid", ex_valid, exp_ev);
      chk("if_ready", if_ready, exp_ir);
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_no_entry: got issue rdn=%0d expected no issue", rdn);
        end else begin
          ent_t e;
          logic [31:0] e_imm, e_r1, e_ba;
          e     = exp_q.pop_front();
          e_imm = ref_imm(e.ins, e.mode);
          e_r1  = opnd(fld(e.ins, 15));
          e_ba  = ((addr_mode ? e_r1 : e.pc) + e_imm) & ~32'd1;
          chk("rdn", rdn, fld(e.ins, 7));
          chk("imm", imm, e_imm);
          chk("pc", pc, e.pc);
          chk("rd_we_out", rd_we_out, e.we);
          chk("rs1d", rs1d, e_r1);
          chk("rs2d", rs2d, opnd(fld(e.ins, 20)));
          chk("branch_addr", branch_addr, e_ba);
          chk("npc", npc, branch_taken ? e_ba : e.pc + 32'd4);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0; ins = 0; pc_in = 0; immode = 0; rd_we = 0; ex_ready = 0;
    wbe = 0; wb_kill = 0; rdn_in = 0; rdd = 0; flush = 0; addr_mode = 0; branch_taken = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " ex_valid"}, ex_valid, 0);
    chk({tag, " if_ready"}, if_ready, 1);
    chk({tag, " imm"}, imm, 0);
    chk({tag, " pc"}, pc, 0);
    chk({tag, " rdn"}, rdn, 0);
    chk({tag, " rs1d"}, rs1d, 0);
    chk({tag, " rs2d"}, rs2d, 0);
    chk({tag, " npc"}, npc, 4);
    chk({tag, " branch_addr"}, branch_addr, 0);
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic [2:0] m, input logic we);
    if_valid = 1; ins = i; pc_in = p; immode = m; rd_we = we;
  endtask

  initial begin
    bit          acc, haz, iss;
    logic [31:0] ri;
    int          pl[$];
    int          r;

    idle();
    rst = 1;
    tick(); tick();
    check_reset("reset");
    rst = 0;
    tick();
    check_reset("post_reset");

    // ADDI x6,x5,3 with x5 = 0x10
    wbe = 1; rdn_in = 5; rdd = 32'h10;
    tick();
    wbe = 0;
    offer(32'h00328313, 32'h200, 3'd0, 1);
    tick();
    if_valid = 0; #2;
    chk("addi ex_valid", ex_valid, 1);
    chk("addi rs1d", rs1d, 32'h10);
    chk("addi imm", imm, 3);
    chk("addi rdn", rdn, 6);
    ex_ready = 1;
    tick();
    ex_ready = 0; wb_kill = 1; rdn_in = 6;
    tick();
    wb_kill = 0;

    // RAW hazard on x7 resolved by a same-cycle writeback
    ex_ready = 1;
    offer(32'h00100393, 32'h10, 3'd0, 1);
    tick();
    offer(32'h00038413, 32'h14, 3'd0, 1); #2;
    chk("raw writer ex_valid", ex_valid, 1);
    chk("raw writer rdn", rdn, 7);
    tick();
    if_valid = 0; #2;
    chk("raw hazard c1", ex_valid, 0);
    tick(); #1;
    chk("raw hazard c2", ex_valid, 0);
    wbe = 1; rdn_in = 7; rdd = 32'hAB; #2;
    chk("raw resolved ex_valid", ex_valid, 1);
    chk("raw bypass rs1d", rs1d, 32'hAB);
    tick();
    wbe = 0; #2;
    chk("raw drained ex_valid", ex_valid, 0);
    chk("raw drained if_ready", if_ready, 1);
    wb_kill = 1; rdn_in = 8;
    tick();
    wb_kill = 0;

    // EX back-pressure for three cycles
    ex_ready = 0;
    offer(32'h00500513, 32'h300, 3'd0, 1);
    tick();
    offer(32'h00100593, 32'h304, 3'd0, 1);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("stall if_ready", if_ready, 0);
      chk("stall ex_valid", ex_valid, 1);
      chk("stall rdn", rdn, 10);
      chk("stall imm", imm, 5);
      chk("stall pc", pc, 32'h300);
      tick();
    end
    ex_ready = 1; if_valid = 0; #2;
    chk("release ex_valid", ex_valid, 1);
    tick(); #1;
    chk("single issue", ex_valid, 0);
    chk("stall no load", rdn, 10);
    ex_ready = 0; wb_kill = 1; rdn_in = 10;
    tick();
    wb_kill = 0;

    // Flush while FULL with a new instruction offered
    offer(32'h00100613, 32'h400, 3'd0, 1);
    tick();
    offer(32'h00100693, 32'h404, 3'd0, 1);
    flush = 1; ex_ready = 1; #2;
    chk("flush ex_valid", ex_valid, 0);
    chk("flush if_ready", if_ready, 1);
    tick();
    flush = 0; if_valid = 0; #2;
    chk("flush empty ex_valid", ex_valid, 0);
    chk("flush discarded offer", rdn, 12);
    offer(32'h00060713, 32'h408, 3'd0, 0);
    tick();
    if_valid = 0; #2;
    chk("flush no pending x12", ex_valid, 1);
    tick();

    // Branch target / next PC
    ex_ready = 0;
    offer(32'hFF800013, 32'h100, 3'd0, 0);
    tick();
    if_valid = 0; addr_mode = 0; branch_taken = 1; #2;
    chk("br imm", imm, 32'hFFFFFFF8);
    chk("br branch_addr", branch_addr, 32'hF8);
    chk("br npc taken", npc, 32'hF8);
    branch_taken = 0; #2;
    chk("br npc not taken", npc, 32'h104);
    addr_mode = 1; #2;
    chk("br rs1-relative", branch_addr, 32'hFFFFFFF8);
    ex_ready = 1;
    tick();
    idle();

    // Reset mid-stall with x9 pending
    wbe = 1; rdn_in = 9; rdd = 32'h55;
    tick();
    wbe = 0; ex_ready = 1;
    offer(32'h00100493, 32'h500, 3'd0, 1);
    tick();
    offer(32'h00048793, 32'h504, 3'd0, 1);
    tick();
    if_valid = 0; #2;
    chk("rst pre stall", ex_valid, 0);
    rst = 1; wbe = 1; rdn_in = 9; rdd = 32'h77;
    offer(32'h00100493, 32'h600, 3'd0, 1);
    tick(); #1;
    check_reset("rst mid");
    rst = 0;
    idle();
    tick(); #1;
    check_reset("rst after");
    ex_ready = 1;
    offer(32'h00048793, 32'h700, 3'd0, 0);
    tick();
    if_valid = 0; #2;
    chk("rst pending cleared", ex_valid, 1);
    chk("rst x9 reads 0", rs1d, 0);
    tick();

    // ---------------- random traffic ----------------
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
    m_full = 0;
    exp_q.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      ri = $urandom;
      ri[11:7]  = 5'($urandom_range(0, 7));
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      if_valid     = ($urandom_range(0, 99) < 60);
      ins          = ri;
      pc_in        = $urandom;
      immode       = 3'($urandom_range(0, 7));
      rd_we        = ($urandom_range(0, 99) < 70);
      ex_ready     = ($urandom_range(0, 99) < 70);
      flush        = ($urandom_range(0, 99) < 4);
      addr_mode    = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      wbe = 0; wb_kill = 0; rdn_in = 0; rdd = $urandom;
      pl.delete();
      for (int k = 1; k < 32; k++) if (m_pend[k]) pl.push_back(k);
      r = $urandom_range(0, 99);
      if (r < 40 && pl.size() > 0) begin
        rdn_in = 5'(pl[$urandom_range(0, pl.size() - 1)]);
        if ($urandom_range(0, 4) == 0) wb_kill = 1; else wbe = 1;
      end else if (r < 50) begin
        rdn_in = 5'($urandom_range(0, 7));
        wbe = 1;
      end

      haz = 0;
      if (m_full) begin
        cur_h = exp_q[0];
        haz = blocked(fld(cur_h.ins, 15)) || blocked(fld(cur_h.ins, 20));
      end
      exp_ev = m_full && !haz && !flush;
      exp_ir = !m_full || (exp_ev && ex_ready) || flush;
      acc    = if_valid && exp_ir && !flush;
      if (acc) exp_q.push_back('{ins, pc_in, immode, rd_we});
      mon_en = 1;

      @(negedge clk); #1;
      iss = exp_ev && ex_ready;
      if (wbe || wb_kill) m_pend[rdn_in] = 0;
      if (iss && cur_h.we && fld(cur_h.ins, 7) != 5'd0) m_pend[fld(cur_h.ins, 7)] = 1;
      if (wbe && rdn_in != 5'd0) m_regs[rdn_in] = rdd;
      if (flush && m_full && exp_q.size() > 0) void'(exp_q.pop_front());
      m_full = flush ? 1'b0 : acc ? 1'b1 : iss ? 1'b0 : m_full;
      tick();
    end
    mon_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter WordSize, default 32, datapath width in bits.
REQ-002 SHALL have parameter RegCount, default 32, number of GPRs; register index width RegBits = clog2(RegCount).
REQ-003 SHALL have ports: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-004 SHALL have fetch-side ports: if_valid in 1 instruction offered; if_ready out 1 stage can accept; ins in WordSize instruction; pc_in in WordSize instruction PC; immode in 3 immediate format; rd_we in 1 instruction writes rd.
REQ-005 SHALL have EX-side ports: ex_valid out 1 decoded instruction valid; ex_ready in 1 EX accepts; rdn out RegBits; rs1d, rs2d, imm, pc out WordSize; rd_we_out out 1.
REQ-006 SHALL have writeback ports: wbe in 1 write enable; wb_kill in 1 clear pending without write; rdn_in in RegBits; rdd in WordSize.
REQ-007 SHALL have control ports: flush in 1 squash held instruction; addr_mode in 1 (0 PC-relative, 1 rs1-relative); branch_taken in 1; npc out WordSize; branch_addr out WordSize.

Function
REQ-008 SHALL hold one instruction in a decode latch with states EMPTY and FULL; latch loads on clk when if_valid && if_ready.
REQ-009 SHALL drive if_ready = EMPTY || (ex_valid && ex_ready) || flush.
REQ-010 SHALL extract rs1n = ins[19:15], rs2n = ins[24:20], rdn = ins[11:7] (low RegBits bits) from the latched instruction.
REQ-011 SHALL generate imm combinationally from the latched instruction: immode 0 I, 1 S, 2 B, 3 U, 4 J (RISC-V sign-extended to WordSize), 5-7 zero.
REQ-012 SHALL keep a pending bit per register; set on issue (ex_valid && ex_ready) when rd_we_out && rdn != 0; cleared when (wbe || wb_kill) for rdn_in.
REQ-013 SHALL give set priority over clear when issue and writeback/kill target the same register in one cycle.
REQ-014 SHALL assert hazard when FULL and rs1n or rs2n (non-zero) is pending and not being cleared by wbe this cycle; wb_kill does not resolve a hazard for the cycle it occurs.
REQ-015 SHALL drive ex_valid = FULL && !hazard && !flush; outputs to EX are combinational from the latch (zero added latency; one cycle fetch-to-issue).
REQ-016 SHALL write rdd into register rdn_in on clk when wbe && rdn_in != 0; register 0 always reads 0; wb_kill alone never writes.
REQ-017 SHALL bypass rdd onto rs1d/rs2d when wbe && rdn_in equals the source index and index != 0.
REQ-018 SHALL, on flush, go to EMPTY next cycle discarding the held instruction and any instruction offered that cycle; no pending bit is set.
REQ-019 SHALL compute branch_addr = (addr_mode ? rs1d : pc) + imm with bit 0 cleared, npc = branch_taken ? branch_addr : pc + 4, modulo 2^WordSize.
REQ-020 SHALL hold latch contents unchanged while FULL and not issuing (stall); no instruction is dropped or duplicated.

Reset
REQ-021 SHALL, with rst high on clk, set latch EMPTY, latched ins/pc/immode/rd_we to 0, all pending bits 0, all GPRs 0; rst overrides flush, load and writeback.
REQ-022 SHALL, during and after reset until first load, present ex_valid 0, if_ready 1, imm/pc/rdn/rs1d/rs2d 0, npc 4, branch_addr 0.

Structure
REQ-023 SHALL place the immode encoding enum and default WordSize/RegCount constants in shared package id_pkg.
REQ-024 SHALL implement the register file with write-bypass as sub-module id_regfile (two read ports, one write port).

Verification
REQ-025 SHALL cover: load x5=0x10 via wbe, issue ADDI x6,x5,3 (ins 0x00328313) -> rs1d 0x10, imm 3, rdn 6, ex_valid 1.
REQ-026 SHALL cover: issue write to x7, next instruction reads x7 -> ex_valid 0 until wbe rdn_in 7 rdd 0xAB, same-cycle issue with rs1d 0xAB.
REQ-027 SHALL cover: ex_ready 0 for 3 cycles while FULL -> if_ready 0, outputs stable, single issue after release.
REQ-028 SHALL cover: flush while FULL with if_valid 1 -> EMPTY next cycle, no ex_valid, pending bits unchanged.
REQ-029 SHALL cover: pc 0x100, imm -8, addr_mode 0, branch_taken 1 -> branch_addr 0xF8, npc 0xF8; branch_taken 0 -> npc 0x104.
REQ-030 SHALL cover: rst asserted mid-stall with x9 pending -> all outputs at reset values, pending cleared, x9 reads 0.
